// File: rtl/node_domain_ctrl.sv
// ---------------------------------------------------------------------------
// node_domain_ctrl
//
// Per-domain clock-enable / reset sequencer for NUM_DOMAINS core domains.
// The block runs on the ungated system clock. It sits between the
// self-awareness unit and the per-core clock-gate cells and reset inputs.
//
// Each domain runs its own OFF -> RST -> RUN -> DRAIN -> OFF sequence:
//   - RST holds the domain reset low, with the clock running, for
//     RESET_CYCLES cycles.
//   - RUN counts cycles into a saturating run counter.
//   - DRAIN keeps the clock running until the domain's bus goes idle,
//     or until DRAIN_TIMEOUT cycles have passed (forced gate-off).
//
// Ports (all vectors are one bit per domain unless noted):
//   clk          ungated system clock
//   res_n        asynchronous active-low reset
//   activate     per-domain run request (level)
//   fin          per-domain finish pulse from the write detector
//   bus_busy     domain has an outstanding AXI transaction
//   clk_en       enable for the domain clock-gate cell
//   res_n_dom    domain reset, active-low
//   running      domain is in RUN
//   done         sticky: last run was ended by fin
//   timeout_err  sticky: last drain hit DRAIN_TIMEOUT
//   run_cycles   NUM_DOMAINS*CNT_WIDTH bits; domain i uses
//                bits [i*CNT_WIDTH +: CNT_WIDTH]
// ---------------------------------------------------------------------------
module node_domain_ctrl #(
    parameter int NUM_DOMAINS   = 2,
    parameter int RESET_CYCLES  = 4,
    parameter int DRAIN_TIMEOUT = 16,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                             clk,
    input  logic                             res_n,
    input  logic [NUM_DOMAINS-1:0]           activate,
    input  logic [NUM_DOMAINS-1:0]           fin,
    input  logic [NUM_DOMAINS-1:0]           bus_busy,
    output logic [NUM_DOMAINS-1:0]           clk_en,
    output logic [NUM_DOMAINS-1:0]           res_n_dom,
    output logic [NUM_DOMAINS-1:0]           running,
    output logic [NUM_DOMAINS-1:0]           done,
    output logic [NUM_DOMAINS-1:0]           timeout_err,
    output logic [NUM_DOMAINS*CNT_WIDTH-1:0] run_cycles
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_RST   = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    // One sequencing counter serves both RST and DRAIN, because a domain
    // is never in both states at once. It is sized for the longer of the two.
    localparam int MAX_SEQ = (RESET_CYCLES > DRAIN_TIMEOUT) ? RESET_CYCLES : DRAIN_TIMEOUT;
    localparam int SEQ_W   = (MAX_SEQ > 1) ? $clog2(MAX_SEQ) : 1;
    localparam logic [SEQ_W-1:0] RST_LAST   = SEQ_W'(RESET_CYCLES - 1);
    localparam logic [SEQ_W-1:0] DRAIN_LAST = SEQ_W'(DRAIN_TIMEOUT - 1);

    for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
        state_e               state_q, state_d;
        logic [SEQ_W-1:0]     seq_cnt_q, seq_cnt_d;
        logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
        logic                 done_q, done_d;
        logic                 terr_q, terr_d;
        logic                 armed_q, armed_d;
        logic                 clk_en_q, res_n_dom_q, running_q;

        always_comb begin
            state_d   = state_q;
            seq_cnt_d = seq_cnt_q;
            run_cnt_d = run_cnt_q;
            done_d    = done_q;
            terr_d    = terr_q;
            armed_d   = armed_q;

            // Seeing activate low re-arms the domain in any state. The fin
            // branch below can still clear armed in the same cycle.
            if (!activate[gi]) begin
                armed_d = 1'b1;
            end

            case (state_q)
                S_OFF: begin
                    if (activate[gi] && armed_q) begin
                        state_d   = S_RST;
                        seq_cnt_d = '0;
                        run_cnt_d = '0;
                        done_d    = 1'b0;
                        terr_d    = 1'b0;
                    end
                end
                S_RST: begin
                    // A core held in reset cannot have bus traffic in
                    // flight, so an abort skips DRAIN.
                    if (!activate[gi]) begin
                        state_d = S_OFF;
                    end else if (seq_cnt_q == RST_LAST) begin
                        state_d = S_RUN;
                    end else begin
                        seq_cnt_d = seq_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (run_cnt_q != '1) begin
                        run_cnt_d = run_cnt_q + 1'b1;
                    end
                    if (fin[gi]) begin
                        state_d   = S_DRAIN;
                        seq_cnt_d = '0;
                        done_d    = 1'b1;
                        armed_d   = 1'b0;
                    end else if (!activate[gi]) begin
                        state_d   = S_DRAIN;
                        seq_cnt_d = '0;
                    end
                end
                S_DRAIN: begin
                    // A clean exit wins over the timeout when both happen
                    // in the same cycle.
                    if (!bus_busy[gi]) begin
                        state_d = S_OFF;
                    end else if (seq_cnt_q == DRAIN_LAST) begin
                        state_d = S_OFF;
                        terr_d  = 1'b1;
                    end else begin
                        seq_cnt_d = seq_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_OFF;
                end
            endcase
        end

        // Outputs are registered from the next state, so they change on the
        // same edge as the state register and feed the gate cells glitch-free.
        always_ff @(posedge clk or negedge res_n) begin
            if (!res_n) begin
                state_q     <= S_OFF;
                seq_cnt_q   <= '0;
                run_cnt_q   <= '0;
                done_q      <= 1'b0;
                terr_q      <= 1'b0;
                armed_q     <= 1'b1;
                clk_en_q    <= 1'b0;
                res_n_dom_q <= 1'b0;
                running_q   <= 1'b0;
            end else begin
                state_q     <= state_d;
                seq_cnt_q   <= seq_cnt_d;
                run_cnt_q   <= run_cnt_d;
                done_q      <= done_d;
                terr_q      <= terr_d;
                armed_q     <= armed_d;
                clk_en_q    <= (state_d != S_OFF);
                res_n_dom_q <= (state_d == S_RUN) || (state_d == S_DRAIN);
                running_q   <= (state_d == S_RUN);
            end
        end

        assign clk_en[gi]      = clk_en_q;
        assign res_n_dom[gi]   = res_n_dom_q;
        assign running[gi]     = running_q;
        assign done[gi]        = done_q;
        assign timeout_err[gi] = terr_q;
        assign run_cycles[gi*CNT_WIDTH +: CNT_WIDTH] = run_cnt_q;
    end

endmodule

// File: tb/tb_node_domain_ctrl.sv
// ---------------------------------------------------------------------------
// Directed testbench for node_domain_ctrl. The main instance uses the
// default parameters. A second single-domain instance with a 4-bit run
// counter is used for the saturation scenario.
// ---------------------------------------------------------------------------
module tb_node_domain_ctrl;

    logic        clk;
    logic        res_n;
    logic [1:0]  activate, fin, bus_busy;
    logic [1:0]  clk_en, res_n_dom, running, done, timeout_err;
    logic [63:0] run_cycles;

    logic [0:0]  act_s, fin_s, busy_s;
    logic [0:0]  clk_en_s, res_n_dom_s, running_s, done_s, terr_s;
    logic [3:0]  run_cycles_s;

    int tests_run;
    int tests_failed;

    node_domain_ctrl #(
        .NUM_DOMAINS(2), .RESET_CYCLES(4), .DRAIN_TIMEOUT(16), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .res_n(res_n), .activate(activate), .fin(fin),
        .bus_busy(bus_busy), .clk_en(clk_en), .res_n_dom(res_n_dom),
        .running(running), .done(done), .timeout_err(timeout_err),
        .run_cycles(run_cycles)
    );

    node_domain_ctrl #(
        .NUM_DOMAINS(1), .RESET_CYCLES(4), .DRAIN_TIMEOUT(16), .CNT_WIDTH(4)
    ) dut_sat (
        .clk(clk), .res_n(res_n), .activate(act_s), .fin(fin_s),
        .bus_busy(busy_s), .clk_en(clk_en_s), .res_n_dom(res_n_dom_s),
        .running(running_s), .done(done_s), .timeout_err(terr_s),
        .run_cycles(run_cycles_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tests_run++;
        if ({clk_en, res_n_dom, running, done, timeout_err} !== 10'b0 || run_cycles !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b rc=%h expected all zero",
                     {clk_en, res_n_dom, running, done, timeout_err}, run_cycles);
        end
        tests_run++;
        if ({clk_en_s, res_n_dom_s, running_s, done_s, terr_s, run_cycles_s} !== 9'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs_sat: got %b expected 0",
                     {clk_en_s, res_n_dom_s, running_s, done_s, terr_s, run_cycles_s});
        end
        res_n = 1'b1;
        repeat (3) tick;
        tests_run++;
        if (clk_en !== 2'b00) begin
            tests_failed++;
            $display("FAIL idle_after_reset: clk_en=%b expected 00", clk_en);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_activate;
        activate = 2'b01;
        for (int c = 1; c <= 4; c++) begin
            tick;
            tests_run++;
            if (clk_en !== 2'b01 || res_n_dom !== 2'b00 || running !== 2'b00) begin
                tests_failed++;
                $display("FAIL rst_phase_c%0d: clk_en=%b res_n_dom=%b running=%b expected 01/00/00",
                         c, clk_en, res_n_dom, running);
            end
        end
        tick;
        tests_run++;
        if (clk_en !== 2'b01 || res_n_dom !== 2'b01 || running !== 2'b01) begin
            tests_failed++;
            $display("FAIL run_entry: clk_en=%b res_n_dom=%b running=%b expected 01/01/01",
                     clk_en, res_n_dom, running);
        end
        $display("[TB] test_activate done");
    endtask

    task automatic test_clean_fin;
        repeat (9) tick;
        fin = 2'b01;
        tick;
        fin = 2'b00;
        tests_run++;
        if (clk_en !== 2'b01 || res_n_dom !== 2'b01 || running !== 2'b00 || run_cycles[31:0] !== 32'd10) begin
            tests_failed++;
            $display("FAIL fin_drain: clk_en=%b res_n_dom=%b running=%b rc=%0d expected 01/01/00/10",
                     clk_en, res_n_dom, running, run_cycles[31:0]);
        end
        tick;
        tests_run++;
        if (clk_en !== 2'b00 || done !== 2'b01 || timeout_err !== 2'b00 || run_cycles[31:0] !== 32'd10) begin
            tests_failed++;
            $display("FAIL fin_off: clk_en=%b done=%b terr=%b rc=%0d expected 00/01/00/10",
                     clk_en, done, timeout_err, run_cycles[31:0]);
        end
        for (int c = 0; c < 3; c++) begin
            tick;
            tests_run++;
            if (clk_en !== 2'b00) begin
                tests_failed++;
                $display("FAIL no_restart_c%0d: clk_en=%b expected 00", c, clk_en);
            end
        end
        activate = 2'b00;
        tick;
        activate = 2'b01;
        tick;
        tests_run++;
        if (clk_en !== 2'b01 || res_n_dom !== 2'b00 || done !== 2'b00 || run_cycles[31:0] !== 32'd0) begin
            tests_failed++;
            $display("FAIL rearm_restart: clk_en=%b res_n_dom=%b done=%b rc=%0d expected 01/00/00/0",
                     clk_en, res_n_dom, done, run_cycles[31:0]);
        end
        activate = 2'b00;
        tick;
        $display("[TB] test_clean_fin done");
    endtask

    task automatic test_drain_timeout;
        int n;
        activate = 2'b01;
        repeat (5) tick;
        tests_run++;
        if (running !== 2'b01) begin
            tests_failed++;
            $display("FAIL to_run_a: running=%b expected 01", running);
        end
        bus_busy = 2'b01;
        activate = 2'b00;
        tick;
        n = 0;
        while (clk_en[0] && res_n_dom[0] && !running[0] && n < 40) begin
            n++;
            tick;
        end
        tests_run++;
        if (n !== 16 || clk_en !== 2'b00 || timeout_err !== 2'b01 || done !== 2'b00 || run_cycles[31:0] !== 32'd1) begin
            tests_failed++;
            $display("FAIL drain_timeout: cycles=%0d clk_en=%b terr=%b done=%b rc=%0d expected 16/00/01/00/1",
                     n, clk_en, timeout_err, done, run_cycles[31:0]);
        end
        activate = 2'b01;
        repeat (5) tick;
        activate = 2'b00;
        tick;
        n = 0;
        while (clk_en[0] && res_n_dom[0] && !running[0] && n < 40) begin
            n++;
            if (n == 6) bus_busy = 2'b00;
            tick;
        end
        bus_busy = 2'b00;
        tests_run++;
        if (n !== 6 || clk_en !== 2'b00 || timeout_err !== 2'b00) begin
            tests_failed++;
            $display("FAIL drain_clean: cycles=%0d clk_en=%b terr=%b expected 6/00/00",
                     n, clk_en, timeout_err);
        end
        $display("[TB] test_drain_timeout done");
    endtask

    task automatic test_fin_and_deact;
        activate = 2'b01;
        repeat (5) tick;
        fin = 2'b01;
        activate = 2'b00;
        tick;
        fin = 2'b00;
        activate = 2'b01;
        tick;
        tests_run++;
        if (clk_en !== 2'b00 || done !== 2'b01) begin
            tests_failed++;
            $display("FAIL fin_deact_off: clk_en=%b done=%b expected 00/01", clk_en, done);
        end
        for (int c = 0; c < 3; c++) begin
            tick;
            tests_run++;
            if (clk_en !== 2'b00) begin
                tests_failed++;
                $display("FAIL armed_cleared_c%0d: clk_en=%b expected 00", c, clk_en);
            end
        end
        activate = 2'b00;
        tick;
        activate = 2'b01;
        tick;
        tests_run++;
        if (clk_en !== 2'b01 || done !== 2'b00) begin
            tests_failed++;
            $display("FAIL fin_deact_rearm: clk_en=%b done=%b expected 01/00", clk_en, done);
        end
        activate = 2'b00;
        tick;
        $display("[TB] test_fin_and_deact done");
    endtask

    task automatic test_rst_abort;
        activate = 2'b01;
        tick;
        tick;
        activate = 2'b00;
        tests_run++;
        if (clk_en !== 2'b01 || res_n_dom !== 2'b00) begin
            tests_failed++;
            $display("FAIL abort_in_rst: clk_en=%b res_n_dom=%b expected 01/00", clk_en, res_n_dom);
        end
        for (int c = 0; c < 2; c++) begin
            tick;
            tests_run++;
            if (clk_en !== 2'b00 || res_n_dom !== 2'b00) begin
                tests_failed++;
                $display("FAIL abort_off_c%0d: clk_en=%b res_n_dom=%b expected 00/00",
                         c, clk_en, res_n_dom);
            end
        end
        $display("[TB] test_rst_abort done");
    endtask

    task automatic test_domain1;
        activate = 2'b10;
        tick;
        tests_run++;
        if (clk_en !== 2'b10 || res_n_dom !== 2'b00) begin
            tests_failed++;
            $display("FAIL dom1_rst: clk_en=%b res_n_dom=%b expected 10/00", clk_en, res_n_dom);
        end
        repeat (4) tick;
        activate = 2'b00;
        tests_run++;
        if (running !== 2'b10 || res_n_dom !== 2'b10) begin
            tests_failed++;
            $display("FAIL dom1_run: running=%b res_n_dom=%b expected 10/10", running, res_n_dom);
        end
        tick;
        tick;
        tests_run++;
        if (clk_en !== 2'b00 || run_cycles[63:32] !== 32'd1 || done !== 2'b00) begin
            tests_failed++;
            $display("FAIL dom1_off: clk_en=%b rc1=%0d done=%b expected 00/1/00",
                     clk_en, run_cycles[63:32], done);
        end
        $display("[TB] test_domain1 done");
    endtask

    task automatic test_saturation;
        logic [3:0] exp_rc;
        act_s = 1'b1;
        repeat (5) tick;
        for (int k = 1; k <= 20; k++) begin
            tick;
            exp_rc = (k > 15) ? 4'd15 : 4'(k);
            tests_run++;
            if (run_cycles_s !== exp_rc) begin
                tests_failed++;
                $display("FAIL saturation_k%0d: rc=%0d expected %0d", k, run_cycles_s, exp_rc);
            end
        end
        act_s = 1'b0;
        tick;
        tick;
        tests_run++;
        if (clk_en_s !== 1'b0 || run_cycles_s !== 4'd15) begin
            tests_failed++;
            $display("FAIL saturation_hold: clk_en=%b rc=%0d expected 0/15", clk_en_s, run_cycles_s);
        end
        $display("[TB] test_saturation done");
    endtask

    task automatic test_async_reset;
        activate = 2'b01;
        repeat (8) tick;
        #2;
        res_n = 1'b0;
        #1;
        tests_run++;
        if ({clk_en, res_n_dom, running, done, timeout_err} !== 10'b0 || run_cycles !== 64'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got %b rc=%h expected all zero",
                     {clk_en, res_n_dom, running, done, timeout_err}, run_cycles);
        end
        activate = 2'b00;
        #2;
        res_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            tests_run++;
            if (clk_en !== 2'b00) begin
                tests_failed++;
                $display("FAIL post_reset_idle_c%0d: clk_en=%b expected 00", c, clk_en);
            end
        end
        activate = 2'b01;
        tick;
        tests_run++;
        if (clk_en !== 2'b01 || res_n_dom !== 2'b00) begin
            tests_failed++;
            $display("FAIL post_reset_start: clk_en=%b res_n_dom=%b expected 01/00", clk_en, res_n_dom);
        end
        activate = 2'b00;
        tick;
        $display("[TB] test_async_reset done");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        res_n    = 1'b0;
        activate = 2'b00;
        fin      = 2'b00;
        bus_busy = 2'b00;
        act_s    = 1'b0;
        fin_s    = 1'b0;
        busy_s   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_activate;
        test_clean_fin;
        test_drain_timeout;
        test_fin_and_deact;
        test_rst_abort;
        test_domain1;
        test_saturation;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/node_domain_ctrl.md
Name: node_domain_ctrl

Overview:
Multi-domain successor to the single-node clock gater. Each of NUM_DOMAINS core domains gets its own sequencer for clock enable and reset, driven by the self-awareness unit's activate and the AXI detector's fin pulse. Each sequencer:
- holds the domain in reset for a programmable number of gated cycles;
- drains outstanding bus traffic before gating off;
- counts run cycles.

The block sits between the self-awareness unit and the per-core clock-gate cells and reset inputs, on the ungated clock.

Parameters:
NUM_DOMAINS, 2, number of independent core domains (>=1)
RESET_CYCLES, 4, cycles the domain clock runs with domain reset held low before release (>=1)
DRAIN_TIMEOUT, 16, max cycles to wait for bus idle before forced gate-off (>=1)
CNT_WIDTH, 32, width of each per-domain run-cycle counter

Ports:
clk  input  1  ungated system clock
res_n  input  1  asynchronous active-low reset
activate  input  NUM_DOMAINS  per-domain run request (level)
fin  input  NUM_DOMAINS  per-domain finish pulse from the write detector
bus_busy  input  NUM_DOMAINS  domain has an outstanding AXI transaction
clk_en  output  NUM_DOMAINS  enable for the domain clock-gate cell
res_n_dom  output  NUM_DOMAINS  domain reset, active-low
running  output  NUM_DOMAINS  domain is in RUN
done  output  NUM_DOMAINS  sticky: last run ended by fin
timeout_err  output  NUM_DOMAINS  sticky: last drain hit DRAIN_TIMEOUT
run_cycles  output  NUM_DOMAINS*CNT_WIDTH  per-domain RUN cycle count; domain i occupies bits [i*CNT_WIDTH +: CNT_WIDTH]

Behaviour:
- Domains are fully independent. Each domain has one FSM with states OFF, RST, RUN, DRAIN.
- All outputs are registered, decoded from the state register plus sticky flops.
- Reset value for every domain, applied asynchronously on res_n low:
  - state = OFF
  - clk_en = 0, res_n_dom = 0, running = 0
  - done = 0, timeout_err = 0, run_cycles = 0
  - armed = 1
- Output decode by state:
  - OFF: clk_en = 0, res_n_dom = 0
  - RST: clk_en = 1, res_n_dom = 0
  - RUN: clk_en = 1, res_n_dom = 1, running = 1
  - DRAIN: clk_en = 1, res_n_dom = 1, running = 0
- Transitions:
  - OFF->RST when activate=1 and armed=1. On entry: rst counter = 0, run_cycles = 0, done = 0, timeout_err = 0. clk_en goes high on the edge after activate is first sampled high.
  - RST->RUN when the rst counter reaches RESET_CYCLES-1. Net effect: res_n_dom stays low for exactly RESET_CYCLES cycles with clk_en high.
  - RST->OFF if activate=0. No drain, because the core is in reset and cannot issue bus traffic. fin is ignored in RST.
  - RUN->DRAIN on fin=1 (sets done=1 and armed=0) or on activate=0. If both occur in the same cycle, the fin path applies (done=1, armed=0).
  - DRAIN: drain counter starts at 0 and increments each cycle.
    - DRAIN->OFF when bus_busy=0.
    - Otherwise DRAIN->OFF when the drain counter reaches DRAIN_TIMEOUT-1; this sets timeout_err=1.
    - If bus_busy=0 and the counter reaches DRAIN_TIMEOUT-1 in the same cycle, exit as clean (no error).
    - activate and fin are ignored in DRAIN.
- armed: cleared by fin-caused shutdown; set again when activate is sampled 0. A domain finished by fin does not restart while activate stays high; it needs a low-then-high on activate.
- run_cycles: +1 for every cycle spent in RUN. Saturates at all-ones with no wrap. Holds its value through DRAIN and OFF, so the count stays readable after the run. Cleared only on OFF->RST or on reset.
- done and timeout_err hold until the next OFF->RST or reset.
- Reset mid-operation forces OFF immediately (async). clk_en and res_n_dom drop together.

Test Plan:
- Single activate, defaults: activate[0] high at cycle 0. Expect clk_en[0]=1 from cycle 1, res_n_dom[0]=0 cycles 1-4, res_n_dom[0]=1 and running[0]=1 from cycle 5; domain 1 stays fully OFF throughout.
- Clean fin: RUN for 10 cycles, then fin[0] pulse with bus_busy[0]=0. Expect DRAIN for 1 cycle, then OFF with clk_en[0]=0, done[0]=1, run_cycles[0]=10, timeout_err[0]=0. activate held high: no restart. Drop activate for 1 cycle and raise it: RST re-entered, done and run_cycles cleared.
- Drain timeout: deassert activate in RUN with bus_busy held 1. Expect exactly 16 DRAIN cycles, then OFF with timeout_err=1, done=0. Repeat with bus_busy dropping after 5 cycles: OFF after 6 DRAIN cycles, no error.
- Simultaneous fin and activate=0 in RUN: expect done=1 and armed cleared. Separately, activate dropped in the 2nd RST cycle: expect OFF on the next edge, and res_n_dom never goes high.
- Saturation: CNT_WIDTH=4, run 20 cycles. Expect run_cycles=15 from cycle 15 onward, no wrap.
- Async reset asserted mid-RUN between clock edges: all outputs go to reset values without waiting for a clock edge. After release, no activity until activate is sampled high.
